// File: rtl/butterfly_pipe.sv
// butterfly_pipe: fully pipelined radix-2 complex butterfly (DIT/DIF) with valid/ready, conj twiddle, /2 scaling and saturation
//   aclk, aresetn        clock (rising edge), asynchronous active-low reset
//   s_valid, s_ready     input handshake; s_ready = !m_valid | m_ready
//   s_mode, s_inv        per-beat 0=DIT/1=DIF, 1=use conj(b)
//   s_scale              per-beat arithmetic shift right by 1 before saturation
//   din_a0, din_a1       operands {imag, real}, W-bit two's complement components
//   din_b                twiddle {imag, real}, V-bit Q1.(V-1) components
//   m_valid, m_ready     output handshake; outputs hold while m_valid & !m_ready
//   dout_p0, dout_p1     results {imag, real}, W+1 bits per component
//   m_ovf                at least one of the four result components saturated
module butterfly_pipe #(
  parameter int COMPLEX_A_DWIDTH = 32,
  parameter int COMPLEX_B_DWIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_mode,
  input  logic                        s_inv,
  input  logic                        s_scale,
  input  logic [COMPLEX_A_DWIDTH-1:0] din_a0,
  input  logic [COMPLEX_A_DWIDTH-1:0] din_a1,
  input  logic [COMPLEX_B_DWIDTH-1:0] din_b,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [COMPLEX_A_DWIDTH+1:0] dout_p0,
  output logic [COMPLEX_A_DWIDTH+1:0] dout_p1,
  output logic                        m_ovf
);
  localparam int W  = COMPLEX_A_DWIDTH / 2;
  localparam int V  = COMPLEX_B_DWIDTH / 2;
  localparam int PW = W + V + 4;
  localparam int RW = W + 4;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (V - 2);
  localparam logic signed [RW-1:0] SMAX = (RW'(1) <<< W) - RW'(1);
  localparam logic signed [RW-1:0] SMIN = -(RW'(1) <<< W);
  function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] y;
    y = (x + HALF) >>> (V - 1);
    return RW'(y);
  endfunction
  // returns {saturated, value[W:0]}
  function automatic logic [W+1:0] sat(input logic signed [RW-1:0] x, input logic s);
    logic signed [RW-1:0] y;
    y = s ? x >>> 1 : x;
    return y > SMAX ? {1'b1, SMAX[W:0]} : y < SMIN ? {1'b1, SMIN[W:0]} : {1'b0, y[W:0]};
  endfunction
  logic ce;
  logic v1_q, v2_q, v3_q, v4_q, m_valid_q, ovf_q, ovf_d;
  logic mode1_q, inv1_q, scale1_q, mode2_q, scale2_q, mode3_q, scale3_q, scale4_q;
  logic signed [W-1:0]  a0_1_q [2];
  logic signed [W-1:0]  a1_1_q [2];
  logic signed [V-1:0]  b_1_q [2];
  logic signed [V:0]    bp_d [2];
  logic signed [V:0]    bp2_q [2];
  logic signed [PW-1:0] pp2_d [4];
  logic signed [PW-1:0] pp2_q [4];
  logic signed [PW-1:0] pp3_d [4];
  logic signed [PW-1:0] pp3_q [4];
  logic signed [W:0]    c2_d [2];
  logic signed [W:0]    c2_q [2];
  logic signed [W:0]    d2_d [2];
  logic signed [W:0]    d2_q [2];
  logic signed [W:0]    c3_q [2];
  logic signed [RW-1:0] t3_d [2];
  logic signed [RW-1:0] t3_q [2];
  logic signed [RW-1:0] p0_4_d [2];
  logic signed [RW-1:0] p0_4_q [2];
  logic signed [RW-1:0] p1_4_d [2];
  logic signed [RW-1:0] p1_4_q [2];
  logic [W+1:0] s0r, s0i, s1r, s1i;
  logic [COMPLEX_A_DWIDTH+1:0] p0_d, p0_q, p1_d, p1_q;
  assign ce      = !m_valid_q || m_ready;
  assign s_ready = ce;
  assign m_valid = m_valid_q;
  assign dout_p0 = p0_q;
  assign dout_p1 = p1_q;
  assign m_ovf   = ovf_q;
  always_comb begin
    bp_d[0]  = (V+1)'(b_1_q[0]);
    bp_d[1]  = inv1_q ? -((V+1)'(b_1_q[1])) : (V+1)'(b_1_q[1]);
    pp2_d[0] = PW'(a1_1_q[0]) * PW'(bp_d[0]);
    pp2_d[1] = PW'(a1_1_q[1]) * PW'(bp_d[1]);
    pp2_d[2] = PW'(a1_1_q[0]) * PW'(bp_d[1]);
    pp2_d[3] = PW'(a1_1_q[1]) * PW'(bp_d[0]);
    for (int i = 0; i < 2; i++) begin
      c2_d[i] = mode1_q ? (W+1)'(a0_1_q[i]) + (W+1)'(a1_1_q[i]) : (W+1)'(a0_1_q[i]);
      d2_d[i] = (W+1)'(a0_1_q[i]) - (W+1)'(a1_1_q[i]);
    end
    t3_d[0]  = rnd(pp2_q[0] - pp2_q[1]);
    t3_d[1]  = rnd(pp2_q[2] + pp2_q[3]);
    pp3_d[0] = PW'(d2_q[0]) * PW'(bp2_q[0]);
    pp3_d[1] = PW'(d2_q[1]) * PW'(bp2_q[1]);
    pp3_d[2] = PW'(d2_q[0]) * PW'(bp2_q[1]);
    pp3_d[3] = PW'(d2_q[1]) * PW'(bp2_q[0]);
    for (int i = 0; i < 2; i++)
      p0_4_d[i] = mode3_q ? RW'(c3_q[i]) : RW'(c3_q[i]) + t3_q[i];
    p1_4_d[0] = mode3_q ? rnd(pp3_q[0] - pp3_q[1]) : RW'(c3_q[0]) - t3_q[0];
    p1_4_d[1] = mode3_q ? rnd(pp3_q[2] + pp3_q[3]) : RW'(c3_q[1]) - t3_q[1];
    s0r   = sat(p0_4_q[0], scale4_q);
    s0i   = sat(p0_4_q[1], scale4_q);
    s1r   = sat(p1_4_q[0], scale4_q);
    s1i   = sat(p1_4_q[1], scale4_q);
    p0_d  = {s0i[W:0], s0r[W:0]};
    p1_d  = {s1i[W:0], s1r[W:0]};
    ovf_d = s0r[W+1] | s0i[W+1] | s1r[W+1] | s1i[W+1];
  end
  // valid chain and output register; bubbles carry zeroed outputs
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      {v1_q, v2_q, v3_q, v4_q, m_valid_q, ovf_q} <= '0;
      p0_q <= '0;
      p1_q <= '0;
    end else if (ce) begin
      v1_q      <= s_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      v4_q      <= v3_q;
      m_valid_q <= v4_q;
      p0_q      <= v4_q ? p0_d : '0;
      p1_q      <= v4_q ? p1_d : '0;
      ovf_q     <= v4_q & ovf_d;
    end
  // datapath stages: operands, products/sums, combine+round, final add; the
  // output register above adds the scale/saturate step for a 4-edge latency
  always_ff @(posedge aclk)
    if (ce) begin
      a0_1_q[0] <= din_a0[W-1:0];
      a0_1_q[1] <= din_a0[2*W-1:W];
      a1_1_q[0] <= din_a1[W-1:0];
      a1_1_q[1] <= din_a1[2*W-1:W];
      b_1_q[0]  <= din_b[V-1:0];
      b_1_q[1]  <= din_b[2*V-1:V];
      mode1_q   <= s_mode;
      inv1_q    <= s_inv;
      scale1_q  <= s_scale;
      pp2_q     <= pp2_d;
      c2_q      <= c2_d;
      d2_q      <= d2_d;
      bp2_q     <= bp_d;
      mode2_q   <= mode1_q;
      scale2_q  <= scale1_q;
      pp3_q     <= pp3_d;
      t3_q      <= t3_d;
      c3_q      <= c2_q;
      mode3_q   <= mode2_q;
      scale3_q  <= scale2_q;
      p0_4_q    <= p0_4_d;
      p1_4_q    <= p1_4_d;
      scale4_q  <= scale3_q;
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: randomized and directed checks of butterfly_pipe against a behavioural model
module tb_butterfly_pipe;
  typedef struct packed { logic [33:0] p0; logic [33:0] p1; logic ovf; } res_t;
  logic aclk = 0, aresetn = 1, s_valid = 0, s_ready, s_mode = 0, s_inv = 0, s_scale = 0;
  logic m_valid, m_ready = 1, m_ovf;
  logic [31:0] din_a0 = 0, din_a1 = 0, din_b = 0;
  logic [33:0] dout_p0, dout_p1;
  int n_cmp = 0, n_bad = 0, lowcnt = 0;
  bit rnd_ready = 0;
  res_t q[$];
  always #5 aclk = ~aclk;
  butterfly_pipe dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_mode(s_mode), .s_inv(s_inv), .s_scale(s_scale),
    .din_a0(din_a0), .din_a1(din_a1), .din_b(din_b),
    .m_valid(m_valid), .m_ready(m_ready),
    .dout_p0(dout_p0), .dout_p1(dout_p1), .m_ovf(m_ovf)
  );
  function automatic logic [31:0] cx(int re, int im);
    return {im[15:0], re[15:0]};
  endfunction
  function automatic longint cr(longint x);
    return (x + (longint'(1) <<< 14)) >>> 15;
  endfunction
  function automatic res_t model(logic [31:0] a0, logic [31:0] a1, logic [31:0] b, logic md, logic iv, logic sc);
    longint ar = $signed(a0[15:0]), ai = $signed(a0[31:16]);
    longint xr = $signed(a1[15:0]), xi = $signed(a1[31:16]);
    longint br = $signed(b[15:0]), bi = $signed(b[31:16]);
    longint dr, di, tr, ti;
    longint v[4];
    res_t r;
    if (iv) bi = -bi;
    if (!md) begin
      tr = cr(xr * br - xi * bi);
      ti = cr(xr * bi + xi * br);
      v = '{ar + tr, ai + ti, ar - tr, ai - ti};
    end else begin
      dr = ar - xr;
      di = ai - xi;
      v = '{ar + xr, ai + xi, cr(dr * br - di * bi), cr(dr * bi + di * br)};
    end
    r.ovf = 0;
    for (int k = 0; k < 4; k++) begin
      if (sc) v[k] = v[k] >>> 1;
      if (v[k] > 65535) begin v[k] = 65535; r.ovf = 1; end
      else if (v[k] < -65536) begin v[k] = -65536; r.ovf = 1; end
    end
    r.p0 = {v[1][16:0], v[0][16:0]};
    r.p1 = {v[3][16:0], v[2][16:0]};
    return r;
  endfunction
  function automatic logic next_ready();
    if (lowcnt > 0) begin
      lowcnt--;
      return 1'b0;
    end
    return rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction
  function automatic logic [15:0] rv();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'($urandom_range(0, 7));
      default: return 16'($urandom);
    endcase
  endfunction
  task automatic pin(input string nm, input res_t got, input res_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model %s: got p0=%h p1=%h ovf=%b want p0=%h p1=%h ovf=%b", nm, got.p0, got.p1, got.ovf, exp.p0, exp.p1, exp.ovf);
    end
  endtask
  task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b, input logic md, input logic iv, input logic sc);
    bit acc = 0;
    int tries = 0;
    while (!acc) begin
      @(negedge aclk);
      s_valid = 1; s_mode = md; s_inv = iv; s_scale = sc;
      din_a0 = a0; din_a1 = a1; din_b = b;
      m_ready = next_ready();
      #1;
      acc = s_ready;
      if (acc) q.push_back(model(a0, a1, b, md, iv, sc));
      else if (++tries > 50) begin
        n_cmp++; n_bad++; acc = 1;
        $display("FAIL send: s_ready stuck at 0 for %0d cycles, want 1", tries);
      end
    end
  endtask
  task automatic send_rand();
    send({rv(), rv()}, {rv(), rv()}, {rv(), rv()}, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 300) begin
      @(negedge aclk);
      s_valid = 0;
      m_ready = next_ready();
      n++;
      #3;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d beats outstanding after %0d cycles, want 0", q.size(), n);
    end
    q.delete();
  endtask
  task automatic lat_check(input string nm, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b, input logic md);
    rnd_ready = 0;
    lowcnt = 0;
    send(a0, a1, b, md, 0, 0);
    for (int j = 0; j < 6; j++) begin
      @(negedge aclk);
      s_valid = 0;
      m_ready = 1;
      #3;
      n_cmp++;
      if (m_valid !== 1'(j == 4)) begin
        n_bad++;
        $display("FAIL %s latency: after edge k+%0d m_valid=%b want %b", nm, j, m_valid, j == 4);
      end
    end
  endtask
  always @(negedge aclk) begin
    #2;
    if (aresetn) begin
      n_cmp++;
      if (s_ready !== (!m_valid || m_ready)) begin
        n_bad++;
        $display("FAIL s_ready: got %b want %b", s_ready, !m_valid || m_ready);
      end
      if (m_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL output: m_valid=1 with p0=%h but no beat outstanding", dout_p0);
        end else begin
          if ({dout_p0, dout_p1, m_ovf} !== q[0]) begin
            n_bad++;
            $display("FAIL output: got p0=%h p1=%h ovf=%b want p0=%h p1=%h ovf=%b", dout_p0, dout_p1, m_ovf, q[0].p0, q[0].p1, q[0].ovf);
          end
          if (m_ready) void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    pin("dit_basic", model(cx(100, 0), cx(200, 0), cx(32767, 0), 0, 0, 0), {34'h0_0000_012C, 34'h0_0001_FF9C, 1'b0});
    pin("sat", model(cx(32767, 0), cx(-32768, -32768), cx(-32768, 32767), 0, 0, 0), {17'd1, 17'd65535, 17'h1FFFF, 17'h18000, 1'b1});
    pin("sat_scale", model(cx(32767, 0), cx(-32768, -32768), cx(-32768, 32767), 0, 0, 1), {17'd0, 17'd49151, 17'h1FFFF, 17'h1C000, 1'b0});
    pin("dif_scale", model(cx(1000, 0), cx(400, 0), cx(0, 32767), 1, 0, 1), {17'd0, 17'd700, 17'd300, 17'd0, 1'b0});
    pin("dif_inv", model(cx(1000, 0), cx(400, 0), cx(0, 32767), 1, 1, 1), {17'd0, 17'd700, 17'h1FED4, 17'd0, 1'b0});
    #1 aresetn = 0;
    #2;
    n_cmp++;
    if ({m_valid, m_ovf, dout_p0, dout_p1} !== '0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: m_valid=%b ovf=%b p0=%h p1=%h s_ready=%b want all 0, s_ready=1", m_valid, m_ovf, dout_p0, dout_p1, s_ready);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1;
    send(cx(100, 0), cx(200, 0), cx(32767, 0), 0, 0, 0);
    send(cx(32767, 0), cx(-32768, -32768), cx(-32768, 32767), 0, 0, 0);
    send(cx(32767, 0), cx(-32768, -32768), cx(-32768, 32767), 0, 0, 1);
    send(cx(1000, 0), cx(400, 0), cx(0, 32767), 1, 0, 1);
    send(cx(1000, 0), cx(400, 0), cx(0, 32767), 1, 1, 1);
    send(cx(100, 0), cx(200, 0), cx(32767, 0), 0, 0, 0);
    send(cx(1000, 0), cx(400, 0), cx(0, 32767), 1, 1, 0);
    drain();
    lat_check("single", cx(123, -45), cx(-678, 90), cx(23170, -23170), 0);
    for (int i = 0; i < 16; i++) send_rand();
    drain();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) lowcnt = 3;
      send_rand();
    end
    drain();
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) send_rand();
    drain();
    rnd_ready = 0;
    for (int i = 0; i < 3; i++) send_rand();
    @(negedge aclk);
    s_valid = 0;
    #3 aresetn = 0;
    #1;
    n_cmp++;
    if ({m_valid, m_ovf, dout_p0, dout_p1} !== '0) begin
      n_bad++;
      $display("FAIL midreset: m_valid=%b ovf=%b p0=%h p1=%h want all 0", m_valid, m_ovf, dout_p0, dout_p1);
    end
    q.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1;
    repeat (8) @(negedge aclk);
    lat_check("after_reset", cx(-5000, 7000), cx(30000, -30000), cx(-32768, -32768), 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, fully pipelined radix-2 complex butterfly for the pfft datapath. Successor to the free-running butterfly.
- Adds valid/ready flow control, per-beat DIT/DIF mode, twiddle conjugation for inverse FFT, optional divide-by-2 scaling, and output saturation with an overflow flag.
- Sits between the pfft stage reorder buffers and twiddle ROM.
- Fixed latency of 4 accepted cycles.

Parameters:
- COMPLEX_A_DWIDTH, 32, packed data width {imag, real}; component width W = COMPLEX_A_DWIDTH/2, two's complement integer; must be even.
- COMPLEX_B_DWIDTH, 32, packed twiddle width {imag, real}; component width V = COMPLEX_B_DWIDTH/2, signed Q1.(V-1); must be even, V >= 3.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input ready.
- s_mode  in  1  0 = DIT, 1 = DIF; sampled with the beat.
- s_inv  in  1  1 = use conj(b); sampled with the beat.
- s_scale  in  1  1 = arithmetic shift right by 1 before saturation; sampled with the beat.
- din_a0  in  COMPLEX_A_DWIDTH  operand a0.
- din_a1  in  COMPLEX_A_DWIDTH  operand a1.
- din_b  in  COMPLEX_B_DWIDTH  twiddle.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- dout_p0  out  COMPLEX_A_DWIDTH+2  result p0, {imag, real}, each W+1 bits.
- dout_p1  out  COMPLEX_A_DWIDTH+2  result p1, same packing.
- m_ovf  out  1  1 = at least one of the 4 output components of this beat saturated.

Behaviour:
- Packing: imag in upper half, real in lower half, for inputs and outputs.
- Arithmetic:
  - DIT: t = a1*b'; p0 = a0 + t; p1 = a0 - t.
  - DIF: p0 = a0 + a1; p1 = (a0 - a1)*b'.
  - b' = b, or conj(b) when s_inv=1. Negation of imag(b) is done in V+1 bits, so -(-2^(V-1)) is exact.
- Complex multiply: re = xr*br - xi*bi, im = xr*bi + xi*br, full precision. Then round half-up: add 2^(V-2), arithmetic shift right V-1.
- Intermediates are kept wide enough that nothing wraps before the final step.
- Final step, per component:
  - if s_scale, arithmetic shift right 1 (floor);
  - saturate to W+1 bits, range [-2^W, 2^W-1];
  - m_ovf = OR of the 4 per-component saturation events.
- Pipeline, 4 register stages, beat-synchronous:
  - S1: register operands and control.
  - S2: DIT = 4 partial products of a1×b'; DIF = a0±a1.
  - S3: DIT = combine + round to t, carry a0; DIF = 4 partial products of (a0-a1)×b'.
  - S4: DIT = a0±t; DIF = combine + round; then scale and saturate; output register.
  - Mode, inv and scale travel with the beat. Mixed modes back-to-back are legal with no bubble.
- Flow control:
  - ce = !m_valid | m_ready; s_ready = ce (combinational).
  - A beat is accepted on a rising edge with s_valid & s_ready.
  - When ce=0 the whole pipeline holds. Bubbles are not compressed.
- Latency: a beat accepted at edge k appears with m_valid=1 after edge k+4 if ce stays 1. Every ce=0 cycle adds 1.
- Output: dout_*/m_ovf are stable while m_valid & !m_ready. Order is preserved; no beat is dropped or duplicated.
- Reset (aresetn=0): immediately m_valid=0, dout_p0=0, dout_p1=0, m_ovf=0, and all stage valid bits cleared.
  - Data registers need not be reset except the output register.
  - Reset mid-stream discards in-flight beats.
  - s_ready=1 after release.
- Throughput: 1 beat/cycle when m_ready=1 continuously.

Test Plan:
- Default params. Values below are (real, imag), with data components in W=16 and twiddle components in V=16.
1. DIT: a0=(100,0), a1=(200,0), b=(0x7FFF,0), inv=0, scale=0 -> p0=(300,0), p1=(-100,0) (p1 real = 0x1FF9C), m_ovf=0.
2. Latency/throughput: single beat at edge k with m_ready=1 -> m_valid=1 only after edge k+4 for exactly 1 cycle. Then 16 back-to-back beats -> 16 consecutive valid outputs, in order, matching the model.
3. Backpressure: stream 8 beats, drop m_ready for 3 cycles mid-stream -> s_ready=0 in those cycles, output held stable, all 8 results correct and in order.
4. Saturation: DIT, a0=(32767,0), a1=(-32768,-32768), b=(-32768,32767) -> t_re=65535, p0_re=65535 (saturated from 98302), m_ovf=1. Same beat with scale=1 -> p0_re=49151, m_ovf=0.
5. DIF + scale + inv: a0=(1000,0), a1=(400,0), b=(0,0x7FFF), scale=1, inv=0 -> p0=(700,0), p1=(0,300). Same with inv=1 -> p1=(0,-300). Interleave DIT/DIF beats back-to-back -> each beat matches its own mode.
6. Reset mid-operation: 3 beats in flight, aresetn low between edges -> m_valid, dout_*, m_ovf go 0 immediately. After release, no stale beat emerges, and a new beat returns its correct result after 4 cycles.
